dcache_controller: RTL and testbench

- Direct-mapped, write-through, no-write-allocate cache controller placed between the RISC-V core's load/store port and the 4-word-burst data memory.
- Holds tag, valid and 128-bit line storage internally.
- Serves read hits with zero wait cycles and sequences the memory for read-miss line refills and write-through stores.
- Stalls the core while memory is busy and keeps saturating hit and miss counters for performance analysis.

---
 rtl/dcache_controller.sv | 142 ++++++++++++++
 tb/tb_dcache_controller.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Zero-wait read hits; line refill and store sequencing toward burst memory.
module dcache_controller #(
    parameter int WIDTH     = 32,
    parameter int ADDR_SIZE = 10,
    parameter int LINES     = 32,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_rd,
    input  logic                 cpu_wr,
    input  logic [ADDR_SIZE-1:0] cpu_addr,
    input  logic [WIDTH-1:0]     cpu_wdata,
    output logic [WIDTH-1:0]     cpu_rdata,
    output logic                 stall,
    output logic                 mem_rd_en,
    output logic                 mem_wr_en,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [WIDTH-1:0]     mem_wdata,
    input  logic                 mem_ready,
    input  logic [4*WIDTH-1:0]   mem_rdata,
    output logic [CNT_W-1:0]     hit_count,
    output logic [CNT_W-1:0]     miss_count
);
    localparam int IW = $clog2(LINES);
    localparam int TW = ADDR_SIZE - IW - 2;

    typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU, DONE} state_t;

    state_t state, state_nx;

    logic [LINES-1:0] valid;
    logic [TW-1:0]    tag_arr  [LINES];
    logic [WIDTH-1:0] line_arr [LINES][4];

    logic [ADDR_SIZE-1:0] lat_addr;
    logic [WIDTH-1:0]     lat_data;
    logic                 lat_rd;

    logic [1:0]    c_off, l_off;
    logic [IW-1:0] c_idx, l_idx;
    logic [TW-1:0] c_tag, l_tag;
    logic          c_hit, l_hit;

    assign c_off = cpu_addr[1:0];
    assign c_idx = cpu_addr[IW+1:2];
    assign c_tag = cpu_addr[ADDR_SIZE-1:IW+2];
    assign l_off = lat_addr[1:0];
    assign l_idx = lat_addr[IW+1:2];
    assign l_tag = lat_addr[ADDR_SIZE-1:IW+2];

    assign c_hit = valid[c_idx] && (tag_arr[c_idx] == c_tag);
    assign l_hit = valid[l_idx] && (tag_arr[l_idx] == l_tag);

    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_data;

    always_comb begin
        state_nx  = state;
        stall     = 1'b0;
        cpu_rdata = '0;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        unique case (state)
            IDLE: begin
                if (cpu_wr) begin
                    state_nx = WR_THRU;
                    stall    = 1'b1;
                end else if (cpu_rd) begin
                    if (c_hit) begin
                        cpu_rdata = line_arr[c_idx][c_off];
                    end else begin
                        state_nx = RD_MISS;
                        stall    = 1'b1;
                    end
                end
            end
            RD_MISS: begin
                mem_rd_en = 1'b1;
                stall     = 1'b1;
                if (mem_ready) state_nx = DONE;
            end
            WR_THRU: begin
                mem_wr_en = 1'b1;
                stall     = 1'b1;
                if (mem_ready) state_nx = DONE;
            end
            DONE: begin
                state_nx = IDLE;
                if (lat_rd) cpu_rdata = line_arr[l_idx][l_off];
            end
            default: state_nx = IDLE;
        endcase
        // The core sees a quiet cache for the whole reset window
        if (!rst) begin
            stall     = 1'b0;
            cpu_rdata = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            valid      <= '0;
            hit_count  <= '0;
            miss_count <= '0;
            lat_addr   <= '0;
            lat_data   <= '0;
            lat_rd     <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE) begin
                if (cpu_wr || (cpu_rd && !c_hit)) begin
                    lat_addr <= cpu_addr;
                    lat_data <= cpu_wdata;
                    lat_rd   <= !cpu_wr;
                end
                if (cpu_rd && !cpu_wr && c_hit && (hit_count != '1))
                    hit_count <= hit_count + 1'b1;
                if (cpu_rd && !cpu_wr && !c_hit && (miss_count != '1))
                    miss_count <= miss_count + 1'b1;
            end
            if ((state == RD_MISS) && mem_ready)
                valid[l_idx] <= 1'b1;
        end
    end

    // Tag and line storage survive reset; only the valid bits are cleared
    always_ff @(posedge clk) begin
        if (rst && mem_ready) begin
            if (state == RD_MISS) begin
                tag_arr[l_idx] <= l_tag;
                for (int k = 0; k < 4; k++)
                    line_arr[l_idx][k] <= mem_rdata[k*WIDTH +: WIDTH];
            end else if ((state == WR_THRU) && l_hit) begin
                line_arr[l_idx][l_off] <= lat_data;
            end
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Scoreboard bench for dcache_controller with a latency-programmable
// burst memory model.
module tb_dcache_controller;
    logic         clk = 1'b0;
    logic         rst;
    logic         cpu_rd, cpu_wr;
    logic [9:0]   cpu_addr;
    logic [31:0]  cpu_wdata, cpu_rdata;
    logic         stall, mem_rd_en, mem_wr_en, mem_ready;
    logic [9:0]   mem_addr;
    logic [31:0]  mem_wdata;
    logic [127:0] mem_rdata;
    logic [15:0]  hit_count, miss_count;

    dcache_controller dut (
        .clk(clk), .rst(rst),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .stall(stall),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int rd_cycles = 0;
    int wr_cycles = 0;
    int lat = 2;
    int lat_cnt = 0;
    logic [31:0] exp_q [$];

    logic [31:0] mem [1024];
    bit          wr_flag [1024];

    function automatic logic [31:0] rd_word(input logic [9:0] a);
        if (wr_flag[a]) return mem[a];
        if (a == 10'h004) return 32'hA5A5_0001;
        return 32'h1000_0000 | {22'd0, a};
    endfunction

    logic [9:0] base;
    assign base = {mem_addr[9:2], 2'b00};

    always @(posedge clk) begin
        mem_ready <= 1'b0;
        if (rst && (mem_rd_en || mem_wr_en) && !mem_ready) begin
            if (lat_cnt >= lat) begin
                mem_ready <= 1'b1;
                lat_cnt   <= 0;
                if (mem_wr_en) begin
                    mem[mem_addr]     <= mem_wdata;
                    wr_flag[mem_addr] <= 1'b1;
                end
                mem_rdata <= {rd_word(base + 10'd3), rd_word(base + 10'd2),
                              rd_word(base + 10'd1), rd_word(base)};
            end else begin
                lat_cnt <= lat_cnt + 1;
            end
        end else begin
            lat_cnt <= 0;
        end
    end

    always @(negedge clk) begin
        logic [31:0] e;
        if (rst && cpu_rd && !stall) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_read: rdata %h, none expected",
                         cpu_rdata);
            end else begin
                e = exp_q.pop_front();
                if (cpu_rdata !== e) begin
                    n_err++;
                    $display("FAIL rdata @%h: got %h want %h",
                             cpu_addr, cpu_rdata, e);
                end
            end
        end
        if (mem_rd_en) rd_cycles++;
        if (mem_wr_en) wr_cycles++;
        if (mem_rd_en && mem_wr_en) begin
            n_cmp++;
            n_err++;
            $display("FAIL en_excl: rd_en=1 wr_en=1 want not both");
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic wait_accept(input string nm);
        int n = 0;
        @(negedge clk);
        while (stall && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (stall) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: stall=1 want 0 within 200", nm);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [9:0] a, input logic [31:0] exp);
        exp_q.push_back(exp);
        cpu_addr = a;
        cpu_rd   = 1'b1;
        wait_accept("rd");
        cpu_rd = 1'b0;
    endtask

    task automatic do_write(input logic [9:0] a, input logic [31:0] d,
                            input logic also_rd);
        if (also_rd) exp_q.push_back(32'h0);
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_wr    = 1'b1;
        cpu_rd    = also_rd;
        wait_accept("wr");
        cpu_wr = 1'b0;
        cpu_rd = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: sim time exceeded, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b0;
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
        cpu_addr = '0;
        cpu_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);
        chk("rst_hits", {16'd0, hit_count}, 32'd0);
        chk("rst_miss", {16'd0, miss_count}, 32'd0);
        chk("rst_en", {30'd0, mem_rd_en, mem_wr_en}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        rd_cycles = 0;
        do_read(10'h004, 32'hA5A5_0001);
        chk("miss1_cnt", {16'd0, miss_count}, 32'd1);
        chk("miss1_rden", {31'd0, rd_cycles > 0}, 32'd1);

        rd_cycles = 0;
        do_read(10'h004, 32'hA5A5_0001);
        do_read(10'h005, 32'h1000_0005);
        do_read(10'h007, 32'h1000_0007);
        chk("hits3_cnt", {16'd0, hit_count}, 32'd3);
        chk("hits3_rden", rd_cycles, 32'd0);
        chk("hits3_miss", {16'd0, miss_count}, 32'd1);

        wr_cycles = 0;
        do_write(10'h006, 32'hDEAD_BEEF, 1'b0);
        chk("wr_hit_wren", {31'd0, wr_cycles > 0}, 32'd1);
        chk("wr_hit_mem", rd_word(10'h006), 32'hDEAD_BEEF);
        rd_cycles = 0;
        do_read(10'h006, 32'hDEAD_BEEF);
        chk("raw_hit_rden", rd_cycles, 32'd0);
        chk("raw_hit_cnt", {16'd0, hit_count}, 32'd4);
        chk("raw_miss_cnt", {16'd0, miss_count}, 32'd1);

        do_write(10'h204, 32'h1234_5678, 1'b0);
        chk("wr_miss_mem", rd_word(10'h204), 32'h1234_5678);
        do_read(10'h004, 32'hA5A5_0001);
        chk("noalloc_hit", {16'd0, hit_count}, 32'd5);
        do_read(10'h204, 32'h1234_5678);
        chk("retag_miss", {16'd0, miss_count}, 32'd2);
        do_read(10'h004, 32'hA5A5_0001);
        chk("evict_miss", {16'd0, miss_count}, 32'd3);
        chk("evict_hits", {16'd0, hit_count}, 32'd5);

        rd_cycles = 0;
        do_write(10'h010, 32'hCAFE_0010, 1'b1);
        chk("both_rden", rd_cycles, 32'd0);
        chk("both_miss", {16'd0, miss_count}, 32'd3);
        chk("both_mem", rd_word(10'h010), 32'hCAFE_0010);

        lat = 20;
        cpu_addr = 10'h300;
        cpu_rd = 1'b1;
        n = 0;
        while (!mem_rd_en && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("midmiss_rden", {31'd0, mem_rd_en}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cpu_rd = 1'b0;
        #1;
        chk("midmiss_stall", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;
        chk("midrst_rden", {31'd0, mem_rd_en}, 32'd0);
        chk("midrst_hits", {16'd0, hit_count}, 32'd0);
        chk("midrst_miss", {16'd0, miss_count}, 32'd0);
        rst = 1'b1;
        lat = 2;
        @(posedge clk);
        #1;
        do_read(10'h004, 32'hA5A5_0001);
        chk("postrst_miss", {16'd0, miss_count}, 32'd1);
        chk("postrst_hits", {16'd0, hit_count}, 32'd0);

        repeat (2) @(posedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
